// File: rtl/ext_pipe_pkg.sv
// Shared definitions for the extension pipeline: op encodings and width.
// Imported by ext_core and ext_pipe.
package ext_pipe_pkg;

    localparam int EXT_OP_W = 3;

    localparam logic [EXT_OP_W-1:0] EXT_OP_SE  = 3'd0;
    localparam logic [EXT_OP_W-1:0] EXT_OP_ZE  = 3'd1;
    localparam logic [EXT_OP_W-1:0] EXT_OP_LS  = 3'd2;
    localparam logic [EXT_OP_W-1:0] EXT_OP_LB  = 3'd3;
    localparam logic [EXT_OP_W-1:0] EXT_OP_LBU = 3'd4;
    localparam logic [EXT_OP_W-1:0] EXT_OP_LH  = 3'd5;
    localparam logic [EXT_OP_W-1:0] EXT_OP_LHU = 3'd6;
    localparam logic [EXT_OP_W-1:0] EXT_OP_ILL = 3'd7;

endpackage

// File: rtl/ext_core.sv
// Combinational extension: immediates and byte/half load-lane extraction.
// Illegal ops and odd halfword offsets give zero data with err set.
module ext_core
    import ext_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int OFF_W  = 2
) (
    input  logic [EXT_OP_W-1:0] op,
    input  logic [IMM_W-1:0]    im,
    input  logic [DATA_W-1:0]   data,
    input  logic [OFF_W-1:0]    off,
    output logic [DATA_W-1:0]   res,
    output logic                err
);

    logic [OFF_W+2:0] sh_amt;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;

    // Little-endian lanes: shift the selected byte down to bit 0
    assign sh_amt = {off, 3'b000};
    assign lane_b = 8'(data >> sh_amt);
    assign lane_h = 16'(data >> sh_amt);

    always_comb begin
        res = '0;
        err = 1'b0;
        case (op)
            EXT_OP_SE:  res = DATA_W'($signed(im));
            EXT_OP_ZE:  res = DATA_W'(im);
            EXT_OP_LS:  res = DATA_W'(im) << (DATA_W - IMM_W);
            EXT_OP_LB:  res = DATA_W'($signed(lane_b));
            EXT_OP_LBU: res = DATA_W'(lane_b);
            EXT_OP_LH: begin
                if (off[0]) err = 1'b1;
                else        res = DATA_W'($signed(lane_h));
            end
            EXT_OP_LHU: begin
                if (off[0]) err = 1'b1;
                else        res = DATA_W'(lane_h);
            end
            default:    err = 1'b1;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined extension unit: one output register plus a one-beat skid,
// valid/ready on both sides, synchronous flush.
module ext_pipe
    import ext_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int OFF_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EXT_OP_W-1:0] in_op,
    input  logic [IMM_W-1:0]    in_im,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [OFF_W-1:0]    in_off,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_err
);

    logic [DATA_W-1:0] core_data;
    logic              core_err;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              skid_err;
    logic              accept;
    logic              out_free;

    ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .OFF_W  (OFF_W)
    ) u_core (
        .op   (in_op),
        .im   (in_im),
        .data (in_data),
        .off  (in_off),
        .res  (core_data),
        .err  (core_err)
    );

    // in_ready depends only on state, never on out_ready
    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign out_free = ~out_valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                out_err    <= skid_err;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_data  <= core_data;
                out_err   <= core_err;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= core_data;
            skid_err   <= core_err;
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed + random bench for ext_pipe with a scoreboard queue.
// Expected beats are pushed on accept and popped on output handshake.
module tb_ext_pipe;
    import ext_pipe_pkg::*;

    localparam int DW = 32;
    localparam int IW = 16;
    localparam int OW = 2;

    logic                clk;
    logic                rst;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [EXT_OP_W-1:0] in_op;
    logic [IW-1:0]       in_im;
    logic [DW-1:0]       in_data;
    logic [OW-1:0]       in_off;
    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       out_data;
    logic                out_err;

    logic [DW:0] sb[$];
    logic [DW:0] exp_beat;
    logic [DW:0] hold_q;
    logic        stall_q;
    int checks = 0;
    int errors = 0;

    ext_pipe #(.DATA_W(DW), .IMM_W(IW), .OFF_W(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_im     (in_im),
        .in_data   (in_data),
        .in_off    (in_off),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: returns {err, data}
    function automatic logic [DW:0] model(input logic [2:0] op,
                                          input logic [IW-1:0] im,
                                          input logic [DW-1:0] d,
                                          input logic [OW-1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0: begin b = d[7:0];   h = d[15:0];  end
            2'd1: begin b = d[15:8];  h = d[23:8];  end
            2'd2: begin b = d[23:16]; h = d[31:16]; end
            default: begin b = d[31:24]; h = {8'h00, d[31:24]}; end
        endcase
        case (op)
            3'd0: return {1'b0, {16{im[15]}}, im};
            3'd1: return {1'b0, 16'h0000, im};
            3'd2: return {1'b0, im, 16'h0000};
            3'd3: return {1'b0, {24{b[7]}}, b};
            3'd4: return {1'b0, 24'h0, b};
            3'd5: return off[0] ? {1'b1, 32'h0} : {1'b0, {16{h[15]}}, h};
            3'd6: return off[0] ? {1'b1, 32'h0} : {1'b0, 16'h0000, h};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    // Scoreboard, stability and accept tracking, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                checks++;
                assert ({out_valid, out_err, out_data} === {1'b1, hold_q})
                else begin
                    errors++;
                    $error("FAIL hold obs=%b/%b/%h exp=1/%b/%h",
                           out_valid, out_err, out_data, hold_q[DW], hold_q[DW-1:0]);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                assert (sb.size() != 0)
                else begin
                    errors++;
                    $error("FAIL unexpected_beat obs=%h exp=none", out_data);
                end
                if (sb.size() != 0) begin
                    exp_beat = sb.pop_front();
                    checks++;
                    assert ({out_err, out_data} === exp_beat)
                    else begin
                        errors++;
                        $error("FAIL sb_beat obs=%b/%h exp=%b/%h",
                               out_err, out_data, exp_beat[DW], exp_beat[DW-1:0]);
                    end
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready)
                sb.push_back(model(in_op, in_im, in_data, in_off));
            stall_q = out_valid && !out_ready && !flush;
            hold_q  = {out_err, out_data};
        end
    end

    task automatic drive_beat(input logic [2:0] op, input logic [IW-1:0] im,
                              input logic [DW-1:0] d, input logic [OW-1:0] off);
        in_valid = 1'b1;
        in_op    = op;
        in_im    = im;
        in_data  = d;
        in_off   = off;
    endtask

    task automatic wait_accept();
        int n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $error("FAIL accept_timeout obs=in_ready=0 exp=1");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [IW-1:0] im,
                        input logic [DW-1:0] d, input logic [OW-1:0] off);
        drive_beat(op, im, d, off);
        wait_accept();
    endtask

    // Send with out_ready=1 and check the result one cycle after accept
    task automatic send_chk(input string tag, input logic [2:0] op,
                            input logic [IW-1:0] im, input logic [DW-1:0] d,
                            input logic [OW-1:0] off, input logic [DW-1:0] ed,
                            input logic ee);
        send(op, im, d, off);
        checks++;
        assert ({out_valid, out_err, out_data} === {1'b1, ee, ed})
        else begin
            errors++;
            $error("FAIL %s obs=%b/%b/%h exp=1/%b/%h",
                   tag, out_valid, out_err, out_data, ee, ed);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int sent;
        int cyc;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_im     = '0;
        in_data   = '0;
        in_off    = '0;
        out_ready = 1'b0;
        stall_q   = 1'b0;
        hold_q    = '0;
        step(2);
        rst = 1'b0;
        step(1);

        // Reset mid-traffic
        send(EXT_OP_SE, 16'h1234, '0, '0);
        send(EXT_OP_ZE, 16'h5678, '0, '0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        assert ({out_valid, out_err, out_data, in_ready} === {1'b0, 1'b0, 32'h0, 1'b1})
        else begin
            errors++;
            $error("FAIL reset obs=%b/%b/%h/%b exp=0/0/0/1",
                   out_valid, out_err, out_data, in_ready);
        end
        step(1);
        rst = 1'b0;
        step(1);

        // Immediates
        out_ready = 1'b1;
        send_chk("se", EXT_OP_SE, 16'h8001, '0, '0, 32'hFFFF8001, 1'b0);
        send_chk("ze", EXT_OP_ZE, 16'h8001, '0, '0, 32'h00008001, 1'b0);
        send_chk("ls", EXT_OP_LS, 16'h8001, '0, '0, 32'h80010000, 1'b0);

        // Loads
        send_chk("lb1", EXT_OP_LB, '0, 32'h80FF7F01, 2'd1, 32'h0000007F, 1'b0);
        send_chk("lb2", EXT_OP_LB, '0, 32'h80FF7F01, 2'd2, 32'hFFFFFFFF, 1'b0);
        send_chk("lbu3", EXT_OP_LBU, '0, 32'h80FF7F01, 2'd3, 32'h00000080, 1'b0);
        send_chk("lh2", EXT_OP_LH, '0, 32'h80FF7F01, 2'd2, 32'hFFFF80FF, 1'b0);
        send_chk("lhu0", EXT_OP_LHU, '0, 32'h80FF7F01, 2'd0, 32'h00007F01, 1'b0);
        send_chk("lh1", EXT_OP_LH, '0, 32'h80FF7F01, 2'd1, 32'h0, 1'b1);
        send_chk("ill", EXT_OP_ILL, 16'hFFFF, 32'hFFFFFFFF, 2'd0, 32'h0, 1'b1);
        step(2);

        // Backpressure: b1 in out, b2 in skid, b3 waits
        out_ready = 1'b0;
        send(EXT_OP_ZE, 16'h0001, '0, '0);
        send(EXT_OP_ZE, 16'h0002, '0, '0);
        drive_beat(EXT_OP_ZE, 16'h0003, '0, '0);
        checks++;
        assert (in_ready === 1'b0)
        else begin
            errors++;
            $error("FAIL bp_ready obs=%b exp=0", in_ready);
        end
        step(1);
        out_ready = 1'b1;
        wait_accept();
        step(4);
        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL bp_drain obs=%0d exp=0", sb.size());
        end

        // Flush with out and skid full plus a new beat
        out_ready = 1'b0;
        send(EXT_OP_ZE, 16'h0011, '0, '0);
        send(EXT_OP_ZE, 16'h0022, '0, '0);
        drive_beat(EXT_OP_ZE, 16'h0033, '0, '0);
        flush = 1'b1;
        step(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        assert ({out_valid, in_ready} === 2'b01)
        else begin
            errors++;
            $error("FAIL flush obs=%b/%b exp=0/1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        step(5);
        checks++;
        assert (out_valid === 1'b0)
        else begin
            errors++;
            $error("FAIL flush_ghost obs=%b exp=0", out_valid);
        end

        // Random traffic
        sent = 0;
        cyc  = 0;
        while (sent < 10000 && cyc < 60000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 4) != 0);
            in_op     = 3'($urandom_range(0, 7));
            in_im     = IW'($urandom);
            in_data   = $urandom;
            in_off    = OW'($urandom_range(0, 3));
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(10);
        checks++;
        assert (sent == 10000 && sb.size() == 0)
        else begin
            errors++;
            $error("FAIL random_drain obs=%0d/%0d exp=10000/0", sent, sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
